// File: rtl/right_rotator_seq.sv
// Sequential right barrel rotator: one log2 stage per clock, LSB of the amount first.
// Valid/ready on both sides; the result stays held in y until downstream accepts it.
module right_rotator_seq #(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2**N-1:0]  a,
  input  logic [N-1:0]     amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2**N-1:0]  y,
  output logic             busy
);

  localparam int WIDTH = 2**N;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q;
  logic [N-1:0]     amt_q;
  logic [WIDTH-1:0] y_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] stage_rot [N];
  logic [WIDTH-1:0] data_d;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      localparam int SH = 2**gi;
      assign stage_rot[gi] = {data_q[SH-1:0], data_q[WIDTH-1:SH]};
    end
  endgenerate

  // Only the stage selected by the counter may rotate, and only if its amount bit is set.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < N; i++) begin
      if ((cnt_q == CW'(i)) && amt_q[i]) begin
        data_d = stage_rot[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      amt_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= a;
            amt_q   <= amt;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          data_q <= data_d;
          if (cnt_q == LAST) begin
            y_q         <= data_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = busy_q;

endmodule

// File: doc/right_rotator_seq.md
Name: right_rotator_seq

Overview:
- Sequential right barrel rotator: rotates a 2**N-bit word right (LSBs wrap into MSBs) by `amt` positions, where `amt` is 0 to 2**N-1.
- Processes one log-stage per clock, LSB of `amt` first; stage i rotates by 2**i when `amt[i]`=1.
- Uses valid/ready handshakes on both sides.
- Undoes the left-rotate path: data rotated left by k and then fed through this block with the same k must return unchanged. The bench checks this round trip.

Parameters:
- N, 3: log2 of the data width; data width WIDTH = 2**N; `amt` width = N; number of stages = N.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  input word and amount are presented.
- in_ready  output  1  block can accept a new operation.
- a  input  2**N  word to rotate.
- amt  input  N  right-rotate amount.
- out_valid  output  1  `y` holds a completed result.
- out_ready  input  1  downstream accepts `y`.
- y  output  2**N  rotated result; registered.
- busy  output  1  an operation is in progress (state SHIFT or DONE).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE; stage counter = 0; data register = 0; amt register = 0.
  - y = 0; out_valid = 0; busy = 0.
  - in_ready is forced 0 while rst_n=0.
- Reset mid-operation aborts the operation. No partial result is ever presented.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture `a` into the data register and `amt` into the amt register, clear the counter, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle with counter=i: if amt_reg[i]=1, data <= {data[2**i-1:0], data[WIDTH-1:2**i]}; otherwise data is unchanged.
  - Then counter <= counter+1.
  - After the stage with i=N-1: load y with the final rotated value, set out_valid=1, go to DONE.
  - All N stages always run, even when `amt`=0. Latency is therefore fixed.
- DONE:
  - out_valid=1; y is stable.
  - On out_ready=1: clear out_valid at that edge and go to IDLE. y keeps its value; only out_valid qualifies it.
  - in_ready stays 0 in DONE. No accept in the same cycle as the output handshake.
- Latency: acceptance edge at cycle t gives out_valid=1 visible from edge t+N onward.
- Minimum throughput: one operation per N+2 cycles when out_ready is held at 1.
- Inputs ignored outside IDLE: in_valid, `a` and `amt` are ignored in SHIFT and DONE. Input changes during an operation must not affect the result.
- Counter:
  - width ceil(log2(N)), minimum 1 bit.
  - Never exceeds N-1 and never wraps while in SHIFT.
- Arithmetic: pure rotation, no bits lost. Rotating by k equals the combinational form {a[k-1:0], a[WIDTH-1:k]}. k=0 returns `a`.
- out_ready held at 0 indefinitely: stay in DONE with y and out_valid stable.
- out_ready=1 outside DONE has no effect.
- Parameter range: N from 1 to 6 (widths 2 to 64). N=1 must yield a 1-stage, 1-cycle SHIFT.

Test Plan:
- Reset and default rotate:
  - Stimulus: reset for 2 cycles, then release. Then a=0x96, amt=1, one-cycle in_valid, out_ready=1.
  - Response: after reset, y=0, out_valid=0, busy=0, in_ready=1. out_valid rises exactly 3 cycles after acceptance with y=0x4B, then returns to IDLE.
- Amount sweep:
  - Stimulus: a=0x96 with amt=3, 4, 0; a=0x01 with amt=7.
  - Response: y=0xD2, 0x69, 0x96, 0x02 respectively. Each result arrives after a fixed 3-cycle latency, including amt=0.
- Backpressure:
  - Stimulus: a=0x96, amt=3; hold out_ready=0 for 5 cycles after out_valid; toggle in_valid, `a` and `amt` during that time.
  - Response: y stays 0xD2, out_valid stays 1, in_ready=0, nothing new is accepted. out_valid clears at the edge where out_ready=1.
- Input isolation:
  - Stimulus: change `a` to 0xFF and `amt` to 5 on the cycle after acceptance of a=0x0F, amt=2.
  - Response: y=0xC3.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for 1 cycle while in SHIFT at counter=1.
  - Response: next cycle out_valid=0, y=0, busy=0. No result is emitted. A new operation then completes normally.
- Round trip:
  - Stimulus: random `a` and k, 1000 iterations, with random out_ready stalls. Feed the left-rotated a by k, with the same k, into this block.
  - Response: y equals the original `a` every time. Each result matches the reference model {a[k-1:0], a[WIDTH-1:k]}.
  - Repeat with N=1 and N=5.
